// File: rtl/dbg.sv
// dbg: debug-bus address types, host opcodes/responses and host FSM states
// St_cnt exists only when DBG_CMD_BURST_EN is defined
package dbg;
   typedef enum logic {Seg_ctl = 1'b0, Seg_rom = 1'b1} seg_t;
   typedef logic [7:0] seg_addr_t;
   typedef struct packed {
      seg_t      seg;
      seg_addr_t addr;
   } addr_t;
   localparam mcs4::byte_t Cmd_rd    = 8'h52;
   localparam mcs4::byte_t Cmd_wr    = 8'h57;
   localparam mcs4::byte_t Cmd_burst = 8'h42;
   localparam mcs4::byte_t Rsp_ack   = 8'h06;
   localparam mcs4::byte_t Rsp_nak   = 8'h15;
   typedef enum logic [2:0] {
      St_idle, St_addr_hi, St_addr_lo, St_data, St_bus, St_wait, St_resp
`ifdef DBG_CMD_BURST_EN
      , St_cnt
`endif
   } host_state_t;
endpackage

// File: rtl/mcs4.sv
// mcs4: base byte type shared by the debug-bus blocks
package mcs4;
   typedef logic [7:0] byte_t;
endpackage

// File: rtl/dbg_cmd_host.sv
// dbg_cmd_host: parses host command bytes into debug-bus cycles, one response byte per transaction
// DBG_CMD_BURST_EN adds the 'B' burst-read opcode
module dbg_cmd_host import dbg::*; #(
   parameter int RD_LAT      = 2,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   output addr_t       dbg_addr,
   output logic        dbg_wen,
   output logic        dbg_ren,
   output mcs4::byte_t dbg_wdata,
   input  mcs4::byte_t dbg_rdata
);
   localparam int Tw = $clog2(TIMEOUT_CYC + 1);
   localparam int Lw = $clog2(RD_LAT + 1);
   localparam int Hw = $bits(addr_t) - 8;
   host_state_t state, state_nx, lo_nx;
   mcs4::byte_t op;
   logic [Hw-1:0] addr_hi;
   logic [Tw-1:0] to_cnt;
   logic [Lw-1:0] lat_cnt;
   logic acc, known, to_exp, lat_done, more;
`ifdef DBG_CMD_BURST_EN
   mcs4::byte_t burst_cnt;
   assign known = rx_data inside {Cmd_rd, Cmd_wr, Cmd_burst};
   assign more  = burst_cnt != 8'd0;
   assign lo_nx = op == Cmd_wr ? St_data : op == Cmd_burst ? St_cnt : St_bus;
`else
   assign known = rx_data inside {Cmd_rd, Cmd_wr};
   assign more  = 1'b0;
   assign lo_nx = op == Cmd_wr ? St_data : St_bus;
`endif
   assign acc      = rx_valid && rx_ready;
   assign to_exp   = to_cnt == Tw'(TIMEOUT_CYC - 1);
   assign lat_done = lat_cnt == Lw'(RD_LAT - 1);

   always_ff @(posedge clk) state <= rst ? St_idle : state_nx;

   // an accepted byte always wins over an expiring timeout
   always_comb begin
      state_nx = state;
      case (state)
         St_idle:    state_nx = acc ? (known ? St_addr_hi : St_resp) : state;
         St_addr_hi: state_nx = acc ? St_addr_lo : to_exp ? St_idle : state;
         St_addr_lo: state_nx = acc ? lo_nx : to_exp ? St_idle : state;
         St_data:    state_nx = acc ? St_bus : to_exp ? St_idle : state;
`ifdef DBG_CMD_BURST_EN
         St_cnt:     state_nx = acc ? St_bus : to_exp ? St_idle : state;
`endif
         St_bus:     state_nx = op == Cmd_wr ? St_resp : St_wait;
         St_wait:    state_nx = lat_done ? St_resp : state;
         St_resp:    state_nx = !tx_ready ? state : more ? St_bus : St_idle;
         default:    state_nx = St_idle;
      endcase
   end

   always_comb begin
      rx_ready = state inside {St_idle, St_addr_hi, St_addr_lo, St_data
`ifdef DBG_CMD_BURST_EN
                               , St_cnt
`endif
                               };
      dbg_wen  = state == St_bus && op == Cmd_wr;
      dbg_ren  = state == St_bus && op != Cmd_wr;
      tx_valid = state == St_resp;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op        <= '0;
         addr_hi   <= '0;
         dbg_addr  <= '0;
         dbg_wdata <= '0;
         tx_data   <= '0;
         to_cnt    <= '0;
         lat_cnt   <= '0;
`ifdef DBG_CMD_BURST_EN
         burst_cnt <= '0;
`endif
      end else begin
         to_cnt  <= rx_ready && state != St_idle && !acc && !to_exp ? to_cnt + 1'b1 : '0;
         lat_cnt <= state == St_wait && !lat_done ? lat_cnt + 1'b1 : '0;
         if (acc && state == St_idle) op <= rx_data;
         if (acc && state == St_idle && !known) tx_data <= Rsp_nak;
         if (acc && state == St_addr_hi) addr_hi <= rx_data[Hw-1:0];
         if (acc && state == St_addr_lo) dbg_addr <= {addr_hi, rx_data};
         if (acc && state == St_data) dbg_wdata <= rx_data;
         if (state == St_bus && op == Cmd_wr) tx_data <= Rsp_ack;
         if (state == St_wait && lat_done) tx_data <= dbg_rdata;
`ifdef DBG_CMD_BURST_EN
         if (acc && state == St_cnt) burst_cnt <= rx_data;
         // burst addresses wrap inside the segment; seg is never touched
         if (state == St_resp && tx_ready && more) begin
            dbg_addr.addr <= dbg_addr.addr + 1'b1;
            burst_cnt     <= burst_cnt - 1'b1;
         end
`endif
      end
   end
endmodule

// File: tb/tb_dbg_cmd_host.sv
// tb_dbg_cmd_host: random command frames against a queue-based scoreboard and a latency-accurate responder
module tb_dbg_cmd_host;
   import dbg::*;
   localparam int RD_LAT = 2;
   localparam int TO     = 64;

   logic clk = 0, rst = 1, rx_valid = 0, tx_ready = 0;
   logic [7:0] rx_data = 0;
   logic rx_ready, tx_valid, dbg_wen, dbg_ren;
   logic [7:0] tx_data;
   addr_t dbg_addr;
   mcs4::byte_t dbg_wdata, dbg_rdata;
   logic [8:0] a9;
   assign a9 = dbg_addr;

   always #5 clk = ~clk;

   dbg_cmd_host #(.RD_LAT(RD_LAT), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .dbg_addr(dbg_addr), .dbg_wen(dbg_wen), .dbg_ren(dbg_ren),
      .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata));

   typedef struct {logic [7:0] d; int lat; bit last;} rsp_t;
   typedef struct {bit we; logic [8:0] a; logic [7:0] wd;} bus_t;
   rsp_t rsp_q[$];
   bus_t bus_q[$];
   int checks = 0, failures = 0, cyc = 0;
   bit hold_tx = 0;
   logic [7:0] mem [512];
   logic [7:0] pipe [RD_LAT];

   // responder: read data appears RD_LAT cycles after the dbg_ren cycle, junk otherwise
   assign dbg_rdata = pipe[RD_LAT-1];
   always @(posedge clk) begin
      cyc <= cyc + 1;
      pipe[0] <= dbg_ren ? mem[a9] : 8'hEE;
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
   end

   function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", n, act, exp, $time);
      end
   endfunction

   initial forever begin
      @(posedge clk); #1;
      tx_ready = !hold_tx && ($urandom_range(0, 2) != 0);
   end

   bit prev_stall = 0, prev_tv = 0, expect_idle = 0;
   logic [7:0] prev_d;
   int last_acc = 0, hold_n = 0;
   logic [8:0] hold_a;
   initial forever begin
      @(negedge clk);
      if (rst) begin
         prev_stall = 0; prev_tv = 0; expect_idle = 0; hold_n = 0;
      end else begin
         if (prev_stall) begin
            chk("tx_hold_valid", tx_valid, 1);
            chk("tx_hold_data", tx_data, prev_d);
         end
         if (expect_idle) chk("tx_after_handshake", tx_valid, 0);
         expect_idle = 0;
         if (tx_valid) chk("rx_ready_in_resp", rx_ready, 0);
         if (hold_n > 0) begin
            chk("addr_hold", a9, hold_a);
            hold_n--;
         end
         if (dbg_wen || dbg_ren) begin
            chk("wen_ren_excl", dbg_wen && dbg_ren, 0);
            if (bus_q.size() == 0) chk("bus_spurious", dbg_wen | dbg_ren, 0);
            else begin
               bus_t e;
               e = bus_q.pop_front();
               chk("bus_we", dbg_wen, e.we);
               chk("bus_addr", a9, e.a);
               if (e.we) chk("bus_wdata", dbg_wdata, e.wd);
            end
            if (dbg_ren) begin
               hold_n = RD_LAT;
               hold_a = a9;
            end
         end
         if (tx_valid && !prev_tv && rsp_q.size() > 0 && rsp_q[0].lat >= 0)
            chk("tx_latency", cyc - last_acc, rsp_q[0].lat);
         if (tx_valid && tx_ready) begin
            if (rsp_q.size() == 0) chk("tx_spurious", tx_valid, 0);
            else begin
               rsp_t r;
               r = rsp_q.pop_front();
               chk("tx_data", tx_data, r.d);
               expect_idle = r.last;
            end
         end
         prev_stall = tx_valid && !tx_ready;
         prev_d = tx_data;
         prev_tv = tx_valid;
         if (rx_valid && rx_ready) last_acc = cyc;
      end
   end

   task automatic send(input logic [7:0] b);
      int n = 0;
      rx_data = b;
      rx_valid = 1;
      @(negedge clk);
      while (!rx_ready) begin
         n++;
         if (n > 2000) begin
            failures++;
            $display("FAIL rx_accept_timeout actual=stuck required=rx_ready");
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $fatal(1);
         end
         @(negedge clk);
      end
      @(posedge clk); #1;
      rx_valid = 0;
   endtask

   task automatic gap(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic wait_drain;
      int n = 0;
      while ((rsp_q.size() != 0 || bus_q.size() != 0) && n < 3000) begin
         @(posedge clk);
         n++;
      end
      chk("drain", rsp_q.size() + bus_q.size(), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic do_read(input logic [15:0] a, input int g);
      bus_q.push_back('{1'b0, a[8:0], 8'h00});
      rsp_q.push_back('{mem[a[8:0]], RD_LAT + 2, 1'b1});
      send(Cmd_rd); gap(g); send(a[15:8]); gap(g); send(a[7:0]);
   endtask

   task automatic do_write(input logic [15:0] a, input logic [7:0] d, input int g);
      bus_q.push_back('{1'b1, a[8:0], d});
      rsp_q.push_back('{Rsp_ack, 2, 1'b1});
      send(Cmd_wr); gap(g); send(a[15:8]); gap(g); send(a[7:0]); gap(g); send(d);
   endtask

   task automatic do_bad(input logic [7:0] op);
      rsp_q.push_back('{Rsp_nak, 1, 1'b1});
      send(op);
   endtask

   task automatic do_abort(input int k);
      send(Cmd_wr);
      if (k > 1) send(8'($urandom));
      if (k > 2) send(8'($urandom));
      gap(TO);
   endtask

   task automatic reset_check;
      @(posedge clk); #1;
      rsp_q.delete();
      bus_q.delete();
      @(negedge clk);
      chk("rst_wen", dbg_wen, 0);
      chk("rst_ren", dbg_ren, 0);
      chk("rst_addr", a9, 0);
      chk("rst_wdata", dbg_wdata, 0);
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_rx_ready", rx_ready, 1);
      @(posedge clk); #1;
      rst = 0;
   endtask

`ifdef DBG_CMD_BURST_EN
   task automatic do_burst(input logic [15:0] a, input logic [7:0] n);
      for (int i = 0; i <= int'(n); i++) begin
         logic [8:0] x;
         x = {a[8], 8'(a[7:0] + i)};
         bus_q.push_back('{1'b0, x, 8'h00});
         rsp_q.push_back('{mem[x], i == 0 ? RD_LAT + 2 : -1, i == int'(n)});
      end
      send(Cmd_burst); send(a[15:8]); send(a[7:0]); send(n);
   endtask
`endif

   initial begin
      #2000000;
      failures++;
      $display("FAIL watchdog actual=running required=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 512; i++) mem[i] = i < 256 ? 8'(i) : 8'($urandom);
      mem[9'h110] = 8'hA5;
      repeat (3) @(posedge clk);
      reset_check();
      do_write(16'h0005, 8'h03, 0); wait_drain();
      do_read(16'h0110, 0); wait_drain();
      do_bad(8'h33); wait_drain();
      do_read(16'h0110, 1); wait_drain();
`ifndef DBG_CMD_BURST_EN
      do_bad(Cmd_burst); wait_drain();
`endif
      send(Cmd_rd); send(8'h00); gap(TO);
      do_write(16'h01C3, 8'h5A, 0); wait_drain();
      do_read(16'h0042, TO - 1); wait_drain();
      hold_tx = 1;
      do_read(16'h0123, 0);
      for (int n = 0; n < 100 && !tx_valid; n++) @(posedge clk);
      chk("hold_reached_resp", tx_valid, 1);
      gap(20);
      hold_tx = 0;
      wait_drain();
`ifdef DBG_CMD_BURST_EN
      do_burst(16'h00FF, 8'd2); wait_drain();
      do_burst(16'h0120, 8'd0); wait_drain();
      do_burst(16'h01F0, 8'd5);
      for (int n = 0; n < 200 && rsp_q.size() > 4; n++) begin @(negedge clk); #1; end
      chk("burst_progress", rsp_q.size(), 4);
      rst = 1;
      reset_check();
      do_read(16'h0007, 0); wait_drain();
`endif
      for (int it = 0; it < 80; it++) begin
         int k;
         logic [15:0] a;
         logic [7:0] op;
         k = $urandom_range(0, 9);
         a = 16'($urandom);
         op = 8'($urandom);
         if (op == Cmd_rd || op == Cmd_wr) op = 8'h33;
`ifdef DBG_CMD_BURST_EN
         if (op == Cmd_burst) op = 8'h33;
`endif
         if (k <= 3) do_read(a, $urandom_range(0, 3));
         else if (k <= 6) do_write(a, 8'($urandom), $urandom_range(0, 3));
         else if (k == 7) do_bad(op);
         else if (k == 8) do_abort($urandom_range(1, 3));
         else begin
            send(Cmd_wr); send(a[15:8]);
            rst = 1;
            reset_check();
         end
         wait_drain();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
